// File: rtl/k423_imem_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : k423_imem_ctrl_pkg
// Brief    : Core-wide widths and instruction-memory controller defaults.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package k423_imem_ctrl_pkg;

  localparam int CORE_ADDR_W  = 32;
  localparam int CORE_XLEN    = 32;
  localparam int CORE_FETCH_W = 32;

  localparam logic [CORE_ADDR_W-1:0] IMEM_BASE_ADDR = 32'h8000_0000;
  localparam int                     IMEM_DEPTH     = 4096;
  localparam int                     IMEM_WAIT_MAX  = 15;
  localparam int                     IMEM_CNT_W     = 4;

  // Offset is already (addr - base); wrap-around below base lands far above the span.
  function automatic logic imem_in_range(input logic [CORE_ADDR_W-1:0] off,
                                         input int unsigned            depth);
    logic [CORE_ADDR_W-1:0] span;
    span = CORE_ADDR_W'(depth) << 2;
    return off < span;
  endfunction

endpackage

`default_nettype wire

// File: rtl/k423_imem_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : k423_imem_ctrl_if
// Brief    : Fetch-unit request/response bundle; names follow the responder view.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface k423_imem_ctrl_if;
  import k423_imem_ctrl_pkg::*;

  logic                    req_vld_i;
  logic                    req_wen_i;
  logic [CORE_ADDR_W-1:0]  req_addr_i;
  logic [CORE_XLEN-1:0]    req_wdata_i;
  logic                    req_rdy_o;
  logic                    rsp_vld_o;
  logic                    rsp_err_o;
  logic [CORE_FETCH_W-1:0] rsp_rdata_o;

  modport slave (
    input  req_vld_i, req_wen_i, req_addr_i, req_wdata_i,
    output req_rdy_o, rsp_vld_o, rsp_err_o, rsp_rdata_o
  );

  modport master (
    output req_vld_i, req_wen_i, req_addr_i, req_wdata_i,
    input  req_rdy_o, rsp_vld_o, rsp_err_o, rsp_rdata_o
  );

endinterface

`default_nettype wire

// File: rtl/k423_imem_ctrl_sram_sp.sv
//------------------------------------------------------------------------------
// Module   : k423_sram_sp
// Brief    : Behavioural single-port synchronous SRAM, 1-cycle read latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module k423_sram_sp #(
  parameter int IDX_W = 12,
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             i_ce,
  input  wire logic             i_we,
  input  wire logic [IDX_W-1:0] i_addr,
  input  wire logic [WIDTH-1:0] i_wdata,
  output logic      [WIDTH-1:0] o_rdata
);

  localparam int c_WORDS = 1 << IDX_W;

  logic [WIDTH-1:0] r_mem [c_WORDS];
  logic [WIDTH-1:0] r_rdata;

  // Read port holds its last value while the macro is deselected.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/k423_imem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : k423_imem_ctrl
// Brief    : Instruction-memory responder driving a 1-cycle single-port SRAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module k423_imem_ctrl
  import k423_imem_ctrl_pkg::*;
#(
  parameter logic [CORE_ADDR_W-1:0] BASE_ADDR   = IMEM_BASE_ADDR,
  parameter int                     DEPTH       = IMEM_DEPTH,
  parameter int                     WAIT_CYCLES = 0,
  parameter int                     IDX_W       = $clog2(DEPTH)
) (
  input  wire logic                    clk_i,
  input  wire logic                    rst_n_i,
  k423_imem_ctrl_if.slave              bus,
  output logic                         sram_ce_o,
  output logic                         sram_we_o,
  output logic [IDX_W-1:0]             sram_addr_o,
  output logic [CORE_XLEN-1:0]         sram_wdata_o,
  input  wire logic [CORE_FETCH_W-1:0] sram_rdata_i
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [IMEM_CNT_W-1:0] c_WAIT = IMEM_CNT_W'(WAIT_CYCLES);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IMEM_CNT_W-1:0]   r_cnt;
  logic [IMEM_CNT_W-1:0]   w_cnt_nxt;
  logic                    r_pend;
  logic                    r_pend_wen;
  logic                    r_pend_err;
  logic [CORE_FETCH_W-1:0] r_hold;
  logic [CORE_FETCH_W-1:0] w_rdata;
  logic [CORE_ADDR_W-1:0]  w_off;
  logic                    w_in_range;
  logic                    w_rdy;
  logic                    w_accept;
  logic                    w_rsp;

  assign w_off      = bus.req_addr_i - BASE_ADDR;
  assign w_in_range = imem_in_range(w_off, DEPTH);
  assign w_rdy      = (r_state == S_IDLE);
  assign w_accept   = bus.req_vld_i & w_rdy;
  // A pending request completes on the first cycle the FSM is back in IDLE.
  assign w_rsp      = r_pend & (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (WAIT_CYCLES != 0)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = c_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == 1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pend     <= 1'b0;
      r_pend_wen <= 1'b0;
      r_pend_err <= 1'b0;
    end else if (w_accept) begin
      r_pend     <= 1'b1;
      r_pend_wen <= bus.req_wen_i;
      r_pend_err <= ~w_in_range;
    end else if (w_rsp) begin
      r_pend     <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = r_hold;
    if (w_rsp) begin
      if (r_pend_err) begin
        w_rdata = '0;
      end else if (!r_pend_wen) begin
        w_rdata = sram_rdata_i;
      end
    end
  end

  // Write acks leave the hold value alone so the fetch stage keeps its instruction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_hold <= '0;
    end else if (w_rsp && !r_pend_wen) begin
      r_hold <= w_rdata;
    end
  end

  assign bus.req_rdy_o   = w_rdy;
  assign bus.rsp_vld_o   = w_rsp;
  assign bus.rsp_err_o   = w_rsp & r_pend_err;
  assign bus.rsp_rdata_o = w_rdata;

  assign sram_ce_o    = w_accept & w_in_range;
  assign sram_we_o    = w_accept & bus.req_wen_i & w_in_range;
  assign sram_addr_o  = w_off[IDX_W+1:2];
  assign sram_wdata_o = bus.req_wdata_i;

endmodule

`default_nettype wire

// File: tb/tb_k423_imem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_k423_imem_ctrl
// Brief    : Self-checking bench for k423_imem_ctrl at WAIT_CYCLES 0, 2 and 3.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_k423_imem_ctrl;
  import k423_imem_ctrl_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  typedef struct {
    int          cyc;
    logic        err;
    logic        wen;
    logic [31:0] dat;
  } rsp_t;

  int total = 0;
  int bad   = 0;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic        d_vld, d_wen;
  logic [31:0] d_addr, d_wdata;

  logic        m_rdy, m_rsp_vld, m_err, m_ce, m_we;
  logic [31:0] m_rdata;
  logic [11:0] m_saddr;

  logic        s0_ce, s0_we, s2_ce, s2_we, s3_ce, s3_we;
  logic [11:0] s0_addr, s2_addr, s3_addr;
  logic [31:0] s0_wdata, s2_wdata, s3_wdata, s0_rdata, s2_rdata, s3_rdata;

  k423_imem_ctrl_if if0();
  k423_imem_ctrl_if if2();
  k423_imem_ctrl_if if3();

  assign if0.req_vld_i = (sel == 2'd0) && d_vld;
  assign if2.req_vld_i = (sel == 2'd2) && d_vld;
  assign if3.req_vld_i = (sel == 2'd3) && d_vld;
  assign if0.req_wen_i = d_wen;
  assign if2.req_wen_i = d_wen;
  assign if3.req_wen_i = d_wen;
  assign if0.req_addr_i = d_addr;
  assign if2.req_addr_i = d_addr;
  assign if3.req_addr_i = d_addr;
  assign if0.req_wdata_i = d_wdata;
  assign if2.req_wdata_i = d_wdata;
  assign if3.req_wdata_i = d_wdata;

  k423_imem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if0),
    .sram_ce_o(s0_ce), .sram_we_o(s0_we), .sram_addr_o(s0_addr),
    .sram_wdata_o(s0_wdata), .sram_rdata_i(s0_rdata));
  k423_imem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if2),
    .sram_ce_o(s2_ce), .sram_we_o(s2_we), .sram_addr_o(s2_addr),
    .sram_wdata_o(s2_wdata), .sram_rdata_i(s2_rdata));
  k423_imem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if3),
    .sram_ce_o(s3_ce), .sram_we_o(s3_we), .sram_addr_o(s3_addr),
    .sram_wdata_o(s3_wdata), .sram_rdata_i(s3_rdata));

  k423_sram_sp #(.IDX_W(12), .WIDTH(32)) m0 (.clk(clk), .i_ce(s0_ce), .i_we(s0_we),
    .i_addr(s0_addr), .i_wdata(s0_wdata), .o_rdata(s0_rdata));
  k423_sram_sp #(.IDX_W(12), .WIDTH(32)) m2 (.clk(clk), .i_ce(s2_ce), .i_we(s2_we),
    .i_addr(s2_addr), .i_wdata(s2_wdata), .o_rdata(s2_rdata));
  k423_sram_sp #(.IDX_W(12), .WIDTH(32)) m3 (.clk(clk), .i_ce(s3_ce), .i_we(s3_we),
    .i_addr(s3_addr), .i_wdata(s3_wdata), .o_rdata(s3_rdata));

  always_comb begin
    m_rdy = if3.req_rdy_o; m_rsp_vld = if3.rsp_vld_o; m_err = if3.rsp_err_o;
    m_rdata = if3.rsp_rdata_o; m_ce = s3_ce; m_we = s3_we; m_saddr = s3_addr;
    if (sel == 2'd0) begin
      m_rdy = if0.req_rdy_o; m_rsp_vld = if0.rsp_vld_o; m_err = if0.rsp_err_o;
      m_rdata = if0.rsp_rdata_o; m_ce = s0_ce; m_we = s0_we; m_saddr = s0_addr;
    end else if (sel == 2'd2) begin
      m_rdy = if2.req_rdy_o; m_rsp_vld = if2.rsp_vld_o; m_err = if2.rsp_err_o;
      m_rdata = if2.rsp_rdata_o; m_ce = s2_ce; m_we = s2_we; m_saddr = s2_addr;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 2'd0; d_vld = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (m_rdy !== 1'b1 || m_rsp_vld !== 1'b0 || m_rdata !== 32'h0 || m_ce !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got rdy=%b vld=%b rdata=%h ce=%b exp 1 0 0 0",
                 i, m_rdy, m_rsp_vld, m_rdata, m_ce);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    d_vld = 1; d_wen = 1; d_addr = BASE; d_wdata = 32'h0000_0013;
    #1;
    total++;
    if (m_ce !== 1'b1 || m_we !== 1'b1 || m_saddr !== 12'd0) begin
      bad++; $display("FAIL b2b_wr0_sram got ce=%b we=%b addr=%0d exp 1 1 0", m_ce, m_we, m_saddr);
    end
    tick();
    d_addr = BASE + 32'd4; d_wdata = 32'h0010_0093;
    #1;
    total++;
    if (m_rsp_vld !== 1'b1 || m_rdata !== 32'h0 || m_saddr !== 12'd1 || m_rdy !== 1'b1) begin
      bad++; $display("FAIL b2b_wr_ack got vld=%b rdata=%h addr=%0d rdy=%b exp 1 0 1 1",
                      m_rsp_vld, m_rdata, m_saddr, m_rdy);
    end
    tick();
    d_vld = 0;
    tick();
    d_vld = 1; d_wen = 0; d_addr = BASE;
    #1;
    total++;
    if (m_rdy !== 1'b1 || m_ce !== 1'b1 || m_we !== 1'b0) begin
      bad++; $display("FAIL b2b_rd0_accept got rdy=%b ce=%b we=%b exp 1 1 0", m_rdy, m_ce, m_we);
    end
    tick();
    d_addr = BASE + 32'd4;
    #1;
    total++;
    if (m_rsp_vld !== 1'b1 || m_rdata !== 32'h0000_0013 || m_rdy !== 1'b1) begin
      bad++; $display("FAIL b2b_rd0_rsp got vld=%b rdata=%h rdy=%b exp 1 00000013 1",
                      m_rsp_vld, m_rdata, m_rdy);
    end
    tick();
    d_vld = 0;
    #1;
    total++;
    if (m_rsp_vld !== 1'b1 || m_rdata !== 32'h0010_0093) begin
      bad++; $display("FAIL b2b_rd1_rsp got vld=%b rdata=%h exp 1 00100093", m_rsp_vld, m_rdata);
    end
    tick();
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (m_rsp_vld !== 1'b0 || m_rdata !== 32'h0010_0093) begin
        bad++; $display("FAIL hold_stall cyc=%0d got vld=%b rdata=%h exp 0 00100093",
                        i, m_rsp_vld, m_rdata);
      end
      tick();
    end
  endtask

  task automatic test_write_read_wait();
    sel = 2'd2;
    d_vld = 1; d_wen = 1; d_addr = BASE + 32'h10; d_wdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if (m_rdy !== 1'b1 || m_ce !== 1'b1 || m_we !== 1'b1 || m_saddr !== 12'd4) begin
      bad++; $display("FAIL wait_wr_accept got rdy=%b ce=%b we=%b addr=%0d exp 1 1 1 4",
                      m_rdy, m_ce, m_we, m_saddr);
    end
    tick();
    d_vld = 0;
    for (int k = 1; k <= 2; k++) begin
      total++;
      if (m_rdy !== 1'b0 || m_rsp_vld !== 1'b0) begin
        bad++; $display("FAIL wait_busy t+%0d got rdy=%b vld=%b exp 0 0", k, m_rdy, m_rsp_vld);
      end
      tick();
    end
    d_vld = 1; d_wen = 0;
    #1;
    total++;
    if (m_rsp_vld !== 1'b1 || m_rdata !== 32'h0 || m_err !== 1'b0 || m_rdy !== 1'b1 || m_ce !== 1'b1) begin
      bad++; $display("FAIL wait_wr_ack got vld=%b rdata=%h err=%b rdy=%b ce=%b exp 1 0 0 1 1",
                      m_rsp_vld, m_rdata, m_err, m_rdy, m_ce);
    end
    tick();
    d_vld = 0;
    for (int k = 4; k <= 5; k++) begin
      total++;
      if (m_rsp_vld !== 1'b0 || m_ce !== 1'b0) begin
        bad++; $display("FAIL wait_rd_quiet t+%0d got vld=%b ce=%b exp 0 0", k, m_rsp_vld, m_ce);
      end
      tick();
    end
    total++;
    if (m_rsp_vld !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || m_err !== 1'b0) begin
      bad++; $display("FAIL wait_rd_rsp got vld=%b rdata=%h err=%b exp 1 deadbeef 0",
                      m_rsp_vld, m_rdata, m_err);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    addrs[0] = 32'h7FFF_FFFC;
    addrs[1] = 32'h8000_4000;
    sel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      d_vld = 1; d_wen = 0; d_addr = addrs[i];
      #1;
      total++;
      if (m_ce !== 1'b0 || m_rdy !== 1'b1) begin
        bad++; $display("FAIL oor_accept addr=%h got ce=%b rdy=%b exp 0 1", addrs[i], m_ce, m_rdy);
      end
      tick();
      d_vld = 0;
      #1;
      total++;
      if (m_rsp_vld !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0 || m_ce !== 1'b0) begin
        bad++; $display("FAIL oor_rsp addr=%h got vld=%b err=%b rdata=%h ce=%b exp 1 1 0 0",
                        addrs[i], m_rsp_vld, m_err, m_rdata, m_ce);
      end
      tick();
      total++;
      if (m_rsp_vld !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0) begin
        bad++; $display("FAIL oor_after addr=%h got vld=%b err=%b rdata=%h exp 0 0 0",
                        addrs[i], m_rsp_vld, m_err, m_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    sel = 2'd3;
    d_vld = 1; d_wen = 1; d_addr = BASE + 32'h8; d_wdata = 32'hA5A5_5A5A;
    tick();
    d_vld = 0;
    tick(); tick(); tick();
    d_vld = 1; d_wen = 0;
    #1;
    total++;
    if (m_rdy !== 1'b1) begin
      bad++; $display("FAIL w3_rdy_after_wr got rdy=%b exp 1", m_rdy);
    end
    tick();
    d_vld = 0;
    tick(); tick(); tick();
    total++;
    if (m_rsp_vld !== 1'b1 || m_rdata !== 32'hA5A5_5A5A) begin
      bad++; $display("FAIL w3_rd_rsp got vld=%b rdata=%h exp 1 a5a55a5a", m_rsp_vld, m_rdata);
    end
    tick();
    d_vld = 1;
    tick();
    d_vld = 0;
    rst_n = 0;
    #1;
    total++;
    if (m_rdy !== 1'b0 || m_rdata !== 32'hA5A5_5A5A) begin
      bad++; $display("FAIL w3_in_wait got rdy=%b rdata=%h exp 0 a5a55a5a", m_rdy, m_rdata);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (m_rsp_vld !== 1'b0 || m_rdy !== 1'b1 || m_rdata !== 32'h0) begin
        bad++; $display("FAIL rst_mid_wait cyc=%0d got vld=%b rdy=%b rdata=%h exp 0 1 0",
                        i, m_rsp_vld, m_rdy, m_rdata);
      end
      tick();
    end
  endtask

  // Reference: one request per free cycle, response exactly W+1 cycles after accept.
  task automatic test_random(input logic [1:0] s, input int w, input int ncyc);
    logic [31:0] mem_m [16];
    logic [31:0] hold_m;
    logic [31:0] exp_d;
    rsp_t        q[$];
    rsp_t        e;
    int          free_at;
    int          init_cnt;
    int          r;
    int          idx;
    logic        rdy_m, in_m, acc_m, exp_vld;
    longint      a;
    hold_m = '0; free_at = 0; init_cnt = 0;
    sel = s;
    for (int c = 0; c < ncyc + w + 3; c++) begin
      if (c >= ncyc) begin
        d_vld = 0;
      end else if (init_cnt < 16) begin
        d_vld = 1; d_wen = 1; d_addr = BASE + 32'(init_cnt * 4); d_wdata = $urandom;
      end else begin
        d_vld = ($urandom_range(0, 3) != 0);
        d_wen = ($urandom_range(0, 2) == 0);
        d_wdata = $urandom;
        r = $urandom_range(0, 9);
        if (r < 8)       d_addr = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        else if (r == 8) d_addr = BASE - 32'($urandom_range(1, 4) * 4);
        else             d_addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7) * 4);
      end
      #1;
      a       = longint'(d_addr);
      in_m    = (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 4);
      rdy_m   = (c >= free_at);
      acc_m   = d_vld && rdy_m;
      exp_vld = (q.size() > 0) && (q[0].cyc == c);
      total++;
      if (m_rdy !== rdy_m || m_rsp_vld !== exp_vld || m_ce !== (acc_m && in_m) ||
          m_we !== (acc_m && in_m && d_wen)) begin
        bad++; $display("FAIL rand_ctrl w=%0d cyc=%0d got rdy=%b vld=%b ce=%b we=%b exp %b %b %b %b",
                        w, c, m_rdy, m_rsp_vld, m_ce, m_we, rdy_m, exp_vld, acc_m && in_m,
                        acc_m && in_m && d_wen);
      end
      exp_d = hold_m;
      if (exp_vld) begin
        e = q.pop_front();
        if (e.err)       exp_d = '0;
        else if (!e.wen) exp_d = e.dat;
        total++;
        if (m_err !== e.err || m_rdata !== exp_d) begin
          bad++; $display("FAIL rand_rsp w=%0d cyc=%0d got err=%b rdata=%h exp %b %h",
                          w, c, m_err, m_rdata, e.err, exp_d);
        end
        if (!e.wen) hold_m = exp_d;
      end else begin
        total++;
        if (m_rdata !== hold_m) begin
          bad++; $display("FAIL rand_hold w=%0d cyc=%0d got rdata=%h exp %h", w, c, m_rdata, hold_m);
        end
      end
      if (acc_m) begin
        idx   = in_m ? int'((d_addr - BASE) >> 2) : 0;
        e.cyc = c + 1 + w;
        e.err = !in_m;
        e.wen = d_wen;
        e.dat = (in_m && !d_wen) ? mem_m[idx] : 32'h0;
        q.push_back(e);
        if (in_m && d_wen) mem_m[idx] = d_wdata;
        free_at = c + 1 + w;
        if (init_cnt < 16) init_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_stall();
    test_write_read_wait();
    test_out_of_range();
    test_reset_mid_wait();
    test_random(2'd0, 0, 400);
    test_random(2'd2, 2, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
